serial_tx_arbiter: RTL

Shares the processor's single 8-bit serial output port between two byte producers: requester 0 is the core's memory-mapped serial store path, requester 1 is the debug/trap message path. Each cycle, a round-robin arbiter accepts at most one byte into a small FIFO. A drain stage pops the FIFO into registered `serial_out`/`serial_wren_out` whenever `serial_ready_in` is high. The block sits between the pipeline's MEM/WB stage and the top-level serial pins.

---
 rtl/serial_pkg.sv | 6 +
 rtl/byte_fifo.sv | 38 +++
 rtl/serial_tx_arbiter.sv | 61 ++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared widths and types for the serial transmit path
package serial_pkg;
    localparam int SERIAL_W = 8;
    localparam int NUM_REQ = 2;
    typedef logic req_id_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular-buffer FIFO with occupancy counter
// Ports: clock, reset (sync, active-high), push/pop strobes, din in,
// dout = head entry, full/empty flags, occupancy = entries held.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int SERIAL_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [SERIAL_W-1:0]       din,
    output logic [SERIAL_W-1:0]       dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int AW = $clog2(DEPTH);
    logic [SERIAL_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign dout = mem[rd_ptr];
    assign full = occupancy == (AW+1)'(DEPTH);
    assign empty = occupancy == '0;
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occupancy <= (push && !pop) ? occupancy + 1'b1 :
                         (pop && !push) ? occupancy - 1'b1 : occupancy;
        end
    end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin share of one serial byte port between two producers
// Ports: clock, reset (sync, active-high); req_data_x/req_valid_x in and
// req_ready_x out per requester (combinational grant); serial_ready_in from
// the sink; registered serial_out, serial_wren_out, busy and tx_count.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SERIAL_W-1:0] req_data_0,
    input  logic                req_valid_0,
    output logic                req_ready_0,
    input  logic [SERIAL_W-1:0] req_data_1,
    input  logic                req_valid_1,
    output logic                req_ready_1,
    input  logic                serial_ready_in,
    output logic [SERIAL_W-1:0] serial_out,
    output logic                serial_wren_out,
    output logic                busy,
    output logic [15:0]         tx_count
);
    localparam int AW = $clog2(DEPTH);
    logic full, empty, push, pop;
    logic [SERIAL_W-1:0] head;
    logic [AW:0] occupancy, occ_next;
    req_id_t last_grant;
    // full uses pre-pop occupancy, so a same-cycle pop never frees a slot early
    assign req_ready_0 = !reset && !full && req_valid_0 && (!req_valid_1 || last_grant == 1'b1);
    assign req_ready_1 = !reset && !full && req_valid_1 && (!req_valid_0 || last_grant == 1'b0);
    assign push = req_ready_0 || req_ready_1;
    assign pop = !empty && serial_ready_in;
    assign occ_next = occupancy + (AW+1)'(push) - (AW+1)'(pop);
    byte_fifo #(.DEPTH(DEPTH), .SERIAL_W(SERIAL_W)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(req_ready_0 ? req_data_0 : req_data_1),
        .dout(head),
        .full(full),
        .empty(empty),
        .occupancy(occupancy)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
            serial_out <= '0;
            serial_wren_out <= 1'b0;
            busy <= 1'b0;
            tx_count <= '0;
        end else begin
            if (push) last_grant <= req_ready_1;
            if (pop) serial_out <= head;
            if (pop) tx_count <= tx_count + 1'b1;
            serial_wren_out <= pop;
            busy <= (occ_next != '0) || pop;
        end
    end
endmodule
